// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus between the fetch stage (master) and memory (slave).
// One request outstanding; a request completes on a cycle with inst_req && inst_ack.
interface fetch_unit_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory requests, 2-entry output FIFO.
//   state   | meaning
//   FETCH   | normal fetching; acked data is pushed into the buffer
//   DISCARD | redirect hit an unacked request; wait for its ack, drop data, then fetch pend_pc
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic         clk,
    input  logic         resetn,
    fetch_unit_if.master mem,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_inst,
    output logic [31:0]  out_pc,
    output logic [5:0]   out_op
);

    typedef enum logic {
        FETCH,
        DISCARD
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic [31:0] buf_inst [2];
    logic [31:0] buf_pc   [2];
    logic        head;
    logic [1:0]  count;

    logic        ack_done;
    logic        pop;
    logic        push;
    logic        tail;
    logic [1:0]  count_next;
    logic [31:0] fetch_pc_next;
    logic [31:0] redirect_tgt;

    assign out_valid = (count != 2'd0);
    assign out_inst  = buf_inst[head];
    assign out_pc    = buf_pc[head];
    assign out_op    = out_inst[31:26];

    always_comb begin
        ack_done      = mem.inst_req & mem.inst_ack;
        pop           = out_valid & out_ready;
        push          = ack_done & (state == FETCH) & ~redirect_valid;
        tail          = head ^ count[0];
        redirect_tgt  = redirect_pc & ~32'h3;
        fetch_pc_next = push ? fetch_pc + 32'd4 : fetch_pc;
        count_next    = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= FETCH;
            fetch_pc      <= RESET_PC;
            pend_pc       <= 32'd0;
            mem.inst_req  <= 1'b0;
            mem.inst_addr <= RESET_PC;
            buf_inst[0]   <= 32'd0;
            buf_inst[1]   <= 32'd0;
            buf_pc[0]     <= 32'd0;
            buf_pc[1]     <= 32'd0;
            head          <= 1'b0;
            count         <= 2'd0;
        end else if (redirect_valid) begin
            count <= 2'd0;
            head  <= 1'b0;
            if (state == DISCARD) begin
                if (ack_done) begin
                    state         <= FETCH;
                    fetch_pc      <= redirect_tgt;
                    mem.inst_req  <= 1'b1;
                    mem.inst_addr <= redirect_tgt;
                end else begin
                    pend_pc <= redirect_tgt;
                end
            end else if (mem.inst_req && !mem.inst_ack) begin
                // request already on the bus must stay stable until acked
                state   <= DISCARD;
                pend_pc <= redirect_tgt;
            end else begin
                fetch_pc      <= redirect_tgt;
                mem.inst_req  <= 1'b1;
                mem.inst_addr <= redirect_tgt;
            end
        end else if (state == DISCARD) begin
            count <= count_next;
            head  <= head ^ pop;
            if (ack_done) begin
                state         <= FETCH;
                fetch_pc      <= pend_pc;
                mem.inst_req  <= 1'b1;
                mem.inst_addr <= pend_pc;
            end
        end else begin
            if (push) begin
                buf_inst[tail] <= mem.inst_rdata;
                buf_pc[tail]   <= mem.inst_addr;
            end
            count         <= count_next;
            head          <= head ^ pop;
            fetch_pc      <= fetch_pc_next;
            mem.inst_req  <= (count_next < 2'd2);
            mem.inst_addr <= fetch_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory/decode model predicts requests and
// buffer contents; expected entries are queued on ack and compared on pop.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [5:0]  out_op;

    fetch_unit_if mem_if ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem            (mem_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_op         (out_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t      exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fetch;
    bit          exp_req;
    bit          drop_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[7:2], 26'h0} ^ 32'h0123_4567;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fetch = RESET_PC;
        exp_req   = 1'b1;
        drop_next = 1'b0;
    endtask

    // One clock: drive at negedge, check and advance the model for the coming posedge.
    task automatic run_cycle(input bit ack, input bit ready, input bit rv, input logic [31:0] rpc);
        entry_t e;
        bit     ack_eff;
        @(negedge clk);
        mem_if.inst_ack   = ack;
        mem_if.inst_rdata = mem_word(mem_if.inst_addr);
        out_ready         = ready;
        redirect_valid    = rv;
        redirect_pc       = rpc;
        #1;
        check_val("req", mem_if.inst_req, exp_req);
        check_val("valid", out_valid, exp_q.size() != 0);
        if (exp_req && !drop_next) check_val("addr", mem_if.inst_addr, exp_fetch);
        if (exp_q.size() != 0 && ready) begin
            e = exp_q.pop_front();
            check_val("out_pc", out_pc, e.pc);
            check_val("out_inst", out_inst, e.inst);
            check_val("out_op", out_op, e.inst[31:26]);
        end
        ack_eff = exp_req && ack;
        if (ack_eff) begin
            if (rv || drop_next) begin
                drop_next = 1'b0;
            end else begin
                exp_q.push_back({mem_word(exp_fetch), exp_fetch});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        if (rv) begin
            exp_q.delete();
            exp_fetch = rpc & ~32'h3;
            if (exp_req && !ack) drop_next = 1'b1;
        end
        exp_req = (exp_q.size() < 2);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=%0t exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_if.inst_ack   = 1'b0;
        mem_if.inst_rdata = 32'd0;
        #12;
        check_val("rst_req", mem_if.inst_req, 1'b0);
        check_val("rst_addr", mem_if.inst_addr, RESET_PC);
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_inst", out_inst, 32'd0);
        check_val("rst_pc", out_pc, 32'd0);
        check_val("rst_op", out_op, 6'd0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();

        // steady stream, one instruction per cycle
        stream(12);

        // backpressure then release
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // slow memory: ack every third cycle
        for (int i = 0; i < 12; i++) run_cycle(i % 3 == 2, 1'b1, 1'b0, 32'd0);

        // fill buffer so no request is pending, then redirect with unaligned target
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b0, 1'b1, 32'h0040_0012);
        stream(6);

        // redirect while a request is pending, ack two cycles later
        run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_1000);
        run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        stream(4);

        // second redirect during DISCARD wins
        run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_3000);
        run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_2000);
        run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        stream(4);

        // redirect coinciding with an ack, then PC wrap-around
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_4000);
        stream(3);
        run_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        stream(5);

        // random traffic with occasional redirects
        for (int i = 0; i < 80; i++) begin
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 15) == 0, $urandom());
        end
        stream(4);

        // asynchronous reset between edges
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_val("arst_req", mem_if.inst_req, 1'b0);
        check_val("arst_valid", out_valid, 1'b0);
        check_val("arst_addr", mem_if.inst_addr, RESET_PC);
        mem_if.inst_ack = 1'b0;
        redirect_valid  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        stream(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS core. It holds the PC and issues word fetches to instruction memory over a req/ack handshake, one request outstanding at a time. Returned instructions are buffered in a 2-entry FIFO and presented to decode with a valid/ready handshake; `out_op` drives the main decoder's `op` input directly. Branch/jump redirects flush the buffer and discard any in-flight response.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC of the first fetch after reset.
- `clk` input 1: clock, all state updates on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `inst_req` output 1: fetch request (registered).
- `inst_addr` output 32: fetch address, word aligned (registered).
- `inst_ack` input 1: memory accepts request and returns data this cycle.
- `inst_rdata` input 32: instruction word, valid when `inst_ack`=1.
- `redirect_valid` input 1: branch/jump taken; flush and refetch.
- `redirect_pc` input 32: redirect target; bits [1:0] ignored (forced 00).
- `out_valid` output 1: head buffer entry valid.
- `out_ready` input 1: decode consumes head entry when `out_valid`&&`out_ready`.
- `out_inst` output 32: head instruction.
- `out_pc` output 32: PC of head instruction.
- `out_op` output 6: `out_inst[31:26]`, to main decoder `op`.

## Operation
- State: `fetch_pc` (32b), FSM {FETCH, DISCARD}, `pend_pc` (32b), buffer of 2 entries {inst, pc}, `count` 0..2.
- Handshake: once `inst_req`=1, `inst_req` and `inst_addr` stay constant until a cycle with `inst_ack`=1. A request completes at that edge. `inst_ack` while `inst_req`=0 is ignored.
- Pop: `out_valid`&&`out_ready` removes the head entry at the edge.
- FETCH:
  - Ack, no redirect: push {`inst_rdata`, `inst_addr`}; `fetch_pc` += 4.
  - Next request: `inst_req` next = (count_next < 2), with `inst_addr` = `fetch_pc` next. Here count_next = count + push − pop. This allows back-to-back requests.
  - If count_next = 2: `inst_req` drops to 0. It re-asserts the cycle after a pop.
- Redirect (any state, priority over push/pop):
  - Buffer cleared (`count`=0) at the edge. `out_valid` is 0 the next cycle.
  - FETCH, no request pending or ack this cycle: ack data dropped. Next `inst_req`=1 with `inst_addr`=`redirect_pc`&~3. `fetch_pc` = that value + 4 once acked.
  - FETCH, request pending without ack: go DISCARD; `pend_pc` = `redirect_pc`&~3; `inst_req`/`inst_addr` held.
  - DISCARD: a further redirect overwrites `pend_pc`.
- DISCARD: hold the request until ack; drop the data; then go FETCH and issue `pend_pc` next cycle. No pushes occur in DISCARD.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Buffer ordering is FIFO; `out_pc` always matches `out_inst`.

## Timing
- Reset values:
  - `inst_req`=0, `inst_addr`=`RESET_PC`, `fetch_pc`=`RESET_PC`, state FETCH, `count`=0.
  - `out_valid`=0, `out_inst`=0, `out_pc`=0, `out_op`=0 (buffer storage cleared).
- First edge after `resetn` rises: `inst_req`=1, `inst_addr`=`RESET_PC`.
- Latency: data acked at edge N appears as `out_valid`=1 in cycle N+1. There is no same-cycle bypass.
- Throughput: 1 instruction/cycle with single-cycle ack and `out_ready`=1.
- Full buffer with a simultaneous pop and ack: legal only if count was 1 (count stays 1). At count=2, `inst_req` is already 0.
- Reset asserted mid-request: everything returns to reset values immediately. The request is abandoned, and memory must tolerate this.
- `out_*` are combinational from the buffer head and are stable while `out_valid`&&!`out_ready`.

## Test plan
- Reset/stream: ack every cycle, `out_ready`=1.
  - `inst_addr` = BFC00000, BFC00004, BFC00008… on consecutive cycles.
  - `out_pc` follows one cycle behind each ack, with matching `out_inst`.
  - `out_op` = `inst_rdata[31:26]`.
- Backpressure: `out_ready`=0 for 5 cycles.
  - Exactly 2 entries are accepted, then `inst_req`=0.
  - On release, entries pop in order and `inst_req` re-asserts the cycle after the first pop.
- Slow memory: ack 3 cycles after req.
  - `inst_addr` is held constant for all 3 cycles.
  - A single push occurs per ack.
- Redirect with no pending request: `redirect_pc`=0040_0012.
  - Buffer empties next cycle.
  - The next `inst_addr` is 0040_0010, and the following one is 0040_0014.
- Redirect while request pending: redirect to 0000_1000; ack arrives 2 cycles later.
  - That ack's data never appears on `out_*`.
  - The next request is 0000_1000.
  - A second redirect to 0000_2000 during DISCARD makes 0000_2000 the next request instead.
- Async reset mid-stream: pull `resetn` low between edges.
  - `inst_req`/`out_valid` drop to 0 immediately.
  - After release, fetch restarts at `RESET_PC`.
